adc1bit: RTL and testbench

//  Receive end of the 1-bit DAC link: recovers WIDTH-bit unsigned samples from
//  a 1-bit delta-sigma bitstream (e.g. a looped-back DAC pin or an external

---
 rtl/adc1bit.sv | 86 ++++++++
 tb/tb_adc1bit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc1bit.sv
`default_nettype none
// ============================================================================
// Module  : adc1bit
// Brief   : 1-bit delta-sigma receiver, 2nd-order CIC decimator by 2^LOG2_R.
// Revision: 1.0  initial release
// ============================================================================
module adc1bit #(
   parameter int WIDTH  = 8,
   parameter int LOG2_R = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             bit_in,
   output logic [WIDTH-1:0] sample,
   output logic             sample_valid,
   output logic             settled
);

   localparam int N     = 2 * LOG2_R + 1;
   localparam int SHIFT = 2 * LOG2_R - WIDTH;
   localparam logic [N-1:0] c_SAT = N'((64'd1 << WIDTH) - 64'd1);

   logic [1:0]        r_sync;
   logic [N-1:0]      r_i1;
   logic [N-1:0]      r_i2;
   logic [N-1:0]      r_i2_d;
   logic [N-1:0]      r_c1_d;
   logic [LOG2_R-1:0] r_cnt;
   logic [WIDTH-1:0]  r_sample;
   logic              r_valid;
   logic              r_seen_one;
   logic              r_settled;

   logic              w_event;
   logic [N-1:0]      w_x;
   logic [N-1:0]      w_c1;
   logic [N-1:0]      w_c2;
   logic [N-1:0]      w_y;
   logic [WIDTH-1:0]  w_sat;

   assign w_event = en && (r_cnt == {LOG2_R{1'b1}});
   assign w_x     = {{(N-1){1'b0}}, r_sync[1]};
   assign w_c1    = r_i2 - r_i2_d;
   assign w_c2    = w_c1 - r_c1_d;
   assign w_y     = w_c2 >> SHIFT;
   // Only an all-ones stream reaches R^2, one code above full scale.
   assign w_sat   = (w_y > c_SAT) ? {WIDTH{1'b1}} : w_y[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync     <= '0;
         r_i1       <= '0;
         r_i2       <= '0;
         r_i2_d     <= '0;
         r_c1_d     <= '0;
         r_cnt      <= '0;
         r_sample   <= '0;
         r_valid    <= 1'b0;
         r_seen_one <= 1'b0;
         r_settled  <= 1'b0;
      end else begin
         // A strobe scheduled on the last enabled cycle completes even if en drops.
         r_valid <= w_event;
         if (en) begin
            r_sync <= {r_sync[0], bit_in};
            r_i1   <= r_i1 + w_x;
            r_i2   <= r_i2 + r_i1;
            r_cnt  <= r_cnt + 1'b1;
            if (w_event) begin
               r_i2_d     <= r_i2;
               r_c1_d     <= w_c1;
               r_sample   <= w_sat;
               r_seen_one <= 1'b1;
               r_settled  <= r_settled | r_seen_one;
            end
         end
      end
   end

   assign sample       = r_sample;
   assign sample_valid = r_valid;
   assign settled      = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_adc1bit.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc1bit
// Brief   : Self-checking bench for adc1bit with an exact-integer CIC model.
// Revision: 1.0  initial release
// ============================================================================
module tb_adc1bit;

   localparam int  R     = 256;
   localparam int  SHIFT = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       bit_in;
   logic [7:0] sample;
   logic       sample_valid;
   logic       settled;

   int checks   = 0;
   int failures = 0;

   int         mode = 0;
   logic [3:0] pat  = 4'b0101;
   logic [1:0] pidx = '0;
   logic [7:0] ds_acc = '0;
   logic [8:0] ds_sum;

   longint m_i1, m_i2, m_s1, m_s2, m_n, m_c2, m_y;
   logic   m_d1, m_d2, m_x;
   int     m_events;
   int     m_sample;
   logic   m_valid;
   longint cyc = 0;

   adc1bit #(.WIDTH(8), .LOG2_R(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .bit_in       (bit_in),
      .sample       (sample),
      .sample_valid (sample_valid),
      .settled      (settled)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Stimulus bit source, updated away from the sampling edge.
   initial begin
      bit_in = 1'b0;
      forever begin
         @(negedge clk);
         case (mode)
            0: bit_in = 1'b0;
            1: bit_in = 1'b1;
            2: begin
               bit_in = pat[pidx];
               pidx   = pidx + 2'd1;
            end
            3: begin
               ds_sum = {1'b0, ds_acc} + 9'd90;
               ds_acc = ds_sum[7:0];
               bit_in = ds_sum[8];
            end
            default: bit_in = 1'($urandom % 2);
         endcase
      end
   end

   // Reference: unbounded integer integrators, comb output as the second
   // difference of I2 taken at the decimation instants.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (rst_n !== 1'b1) begin
            m_i1 = 0; m_i2 = 0; m_s1 = 0; m_s2 = 0; m_n = 0;
            m_d1 = 0; m_d2 = 0; m_events = 0; m_sample = 0; m_valid = 0;
         end else begin
            cyc++;
            m_valid = 1'b0;
            if (en === 1'b1) begin
               m_x = m_d2;
               if ((m_n % R) == R - 1) begin
                  m_c2 = m_i2 - 2 * m_s1 + m_s2;
                  m_s2 = m_s1;
                  m_s1 = m_i2;
                  m_y  = m_c2 >>> SHIFT;
                  m_sample = (m_y > 255) ? 255 : int'(m_y);
                  m_valid  = 1'b1;
                  m_events++;
               end
               m_i2 = m_i2 + m_i1;
               m_i1 = m_i1 + longint'(m_x);
               m_d2 = m_d1;
               m_d1 = bit_in;
               m_n++;
            end
         end
         #1;
         check("sample", longint'(sample), longint'(m_sample));
         check("sample_valid", longint'(sample_valid), longint'(m_valid));
         check("settled", longint'(settled), (m_events >= 2) ? 1 : 0);
      end
   end

   task automatic wait_strobe(output int n, output longint at);
      n  = 0;
      at = 0;
      while (n < 1000) begin
         @(posedge clk);
         #2;
         n++;
         if (sample_valid) begin
            at = cyc;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL strobe_timeout: got none expected strobe within 1000 cycles");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   int     n;
   longint t0, t1;
   int     exp_pat [3] = '{128, 64, 192};
   logic [3:0] pats [3] = '{4'b0101, 4'b0001, 4'b0111};

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("rst_sample", longint'(sample), 0);
      check("rst_valid", longint'(sample_valid), 0);
      check("rst_settled", longint'(settled), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // all zeros
      for (int i = 1; i <= 4; i++) begin
         wait_strobe(n, t0);
         check("zeros_sample", longint'(sample), 0);
         if (i == 1) check("settled_after_1st", longint'(settled), 0);
         if (i == 2) check("settled_after_2nd", longint'(settled), 1);
      end

      // all ones, integrators wrap many times
      mode = 1;
      for (int i = 1; i <= 20; i++) begin
         wait_strobe(n, t0);
         if (i >= 3) check("ones_saturated", longint'(sample), 255);
      end

      // periodic patterns
      for (int p = 0; p < 3; p++) begin
         pat  = pats[p];
         mode = 2;
         for (int i = 1; i <= 4; i++) wait_strobe(n, t0);
         check("pattern_sample", longint'(sample), longint'(exp_pat[p]));
      end

      // first-order modulator loopback at 0x5A
      ds_acc = '0;
      mode   = 3;
      for (int i = 1; i <= 3; i++) wait_strobe(n, t0);
      wait_strobe(n, t1);
      check("ds_in_range", (sample >= 8'h59 && sample <= 8'h5B) ? 1 : 0, 1);
      check("ds_spacing", t1 - t0, 256);

      // enable hold mid-window
      pat  = 4'b0101;
      mode = 2;
      for (int i = 1; i <= 3; i++) wait_strobe(n, t0);
      repeat (50) @(negedge clk);
      en = 1'b0;
      repeat (100) @(negedge clk);
      en = 1'b1;
      wait_strobe(n, t1);
      check("hold_spacing", t1 - t0, 356);
      check("hold_sample", longint'(sample), 128);

      // asynchronous reset between edges
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_sample", longint'(sample), 0);
      check("async_valid", longint'(sample_valid), 0);
      check("async_settled", longint'(settled), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_strobe(n, t0);
      check("first_strobe_latency", longint'(n), 256);
      check("first_strobe_settled", longint'(settled), 0);

      // random bits with random enable gaps
      mode = 4;
      repeat (12000) begin
         @(negedge clk);
         en = (($urandom % 8) != 0);
      end
      @(negedge clk);
      en = 1'b1;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
